// File: rtl/barret_pkg.sv
// Shared constants for the Barrett modular multiplier (modulus 2339).
//   Q   : modulus
//   QW  : operand/result width
//   PW  : product width, which must hold (Q-1)^2
//   K   : Barrett shift, 2*QW
//   MU  : floor(2^K / Q)
//   MUW : width of MU
// mu_of() recomputes MU so the top level can reject an inconsistent edit
// during elaboration.
package barret_pkg;

  localparam int unsigned Q   = 2339;
  localparam int unsigned QW  = 12;
  localparam int unsigned PW  = 23;
  localparam int unsigned K   = 2 * QW;
  localparam int unsigned MU  = 7172;
  localparam int unsigned MUW = 13;

  function automatic int unsigned mu_of(input int unsigned q, input int unsigned k);
    longint unsigned num;
    num = 64'd1 << k;
    return 32'(num / 64'(q));
  endfunction

endpackage

// File: rtl/barret_modmul_pipe_if.sv
// Streaming bus for barret_modmul_pipe.
//   in_valid/in_ready   : operand handshake, with operands din_a and din_b
//   out_valid/out_ready : result handshake, with result dout_r
//   dout_err            : out-of-range flag; present only when BARRET_RANGE_CHECK_EN is defined
// master : the side that drives operands and consumes results (source/sink)
// slave  : the multiplier
interface barret_modmul_pipe_if;
  import barret_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] din_a;
  logic [QW-1:0] din_b;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] dout_r;
`ifdef BARRET_RANGE_CHECK_EN
  logic          dout_err;
`endif

  modport master (
    output in_valid, din_a, din_b, out_ready,
    input  in_ready, out_valid, dout_r
`ifdef BARRET_RANGE_CHECK_EN
    , input dout_err
`endif
  );

  modport slave (
    input  in_valid, din_a, din_b, out_ready,
    output in_ready, out_valid, dout_r
`ifdef BARRET_RANGE_CHECK_EN
    , output dout_err
`endif
  );

endinterface

// File: rtl/barret_reduce_pipe.sv
// Barrett reduction stages S2..S4 for x < 2^PW.
//   clk, rst : clock and synchronous active-high reset
//   advance  : global pipeline enable; when low, every stage holds
//   x_valid  : S1 valid
//   x        : S1 product
//   r_valid  : S4 valid
//   r        : x mod Q
// S2 estimates the quotient qh = (x*MU) >> K. S3 forms r = x - qh*Q, which
// is below 3Q, so QW+2 bits suffice and wrap-around in the subtraction is
// harmless. S4 applies a final correction of at most 2Q.
module barret_reduce_pipe
  import barret_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          x_valid,
  input  logic [PW-1:0] x,
  output logic          r_valid,
  output logic [QW-1:0] r
);

  localparam logic [QW+1:0] Q_R  = (QW+2)'(Q);
  localparam logic [QW+1:0] Q2_R = (QW+2)'(2 * Q);

  logic          v2_q, v2_d;
  logic [PW-1:0] x2_q, x2_d;
  logic [QW-1:0] qh2_q, qh2_d;
  logic          v3_q, v3_d;
  logic [QW+1:0] r3_q, r3_d;
  logic          v4_q, v4_d;
  logic [QW-1:0] r4_q, r4_d;
  logic [QW+1:0] r3_fix;

  always_comb begin
    // NOTE: every variable gets a hold value before any branch, so no path leaves one unassigned and no latch is inferred.
    v2_d   = v2_q;
    x2_d   = x2_q;
    qh2_d  = qh2_q;
    v3_d   = v3_q;
    r3_d   = r3_q;
    v4_d   = v4_q;
    r4_d   = r4_q;

    r3_fix = r3_q;
    if (r3_q >= Q2_R) begin
      r3_fix = r3_q - Q2_R;
    end else if (r3_q >= Q_R) begin
      r3_fix = r3_q - Q_R;
    end

    if (advance) begin
      // S2: the full product is PW+MUW bits; bits [K+QW-1:K] form the quotient estimate.
      v2_d  = x_valid;
      x2_d  = x;
      qh2_d = QW'(((PW + MUW)'(x) * (PW + MUW)'(MU)) >> K);
      // S3: arithmetic is modulo 2^(QW+2), which is exact because 0 <= r < 3Q.
      v3_d  = v2_q;
      r3_d  = (QW + 2)'(x2_q) - (QW + 2)'(qh2_q * Q);
      // S4
      v4_d  = v3_q;
      r4_d  = QW'(r3_fix);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset along with the valids, so a bubble never carries X out of reset.
    if (rst) begin
      v2_q  <= 1'b0;
      x2_q  <= '0;
      qh2_q <= '0;
      v3_q  <= 1'b0;
      r3_q  <= '0;
      v4_q  <= 1'b0;
      r4_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make all stages sample their old neighbours at the same edge.
      v2_q  <= v2_d;
      x2_q  <= x2_d;
      qh2_q <= qh2_d;
      v3_q  <= v3_d;
      r3_q  <= r3_d;
      v4_q  <= v4_d;
      r4_q  <= r4_d;
    end
  end

  assign r_valid = v4_q;
  assign r       = r4_q;

endmodule

// File: rtl/barret_modmul_pipe.sv
// Pipelined modular multiplier: (a*b) mod Q.
// There are four stages, and latency is 4 cycles when there is no back-pressure.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; drops every item in flight
//   io  : barret_modmul_pipe_if.slave (operand and result valid/ready streams)
// This module owns S1 (the product), the handshake, and the optional error
// sideband. barret_reduce_pipe does S2..S4.
// All stages share one enable: advance = !out_valid | out_ready. While the
// output is stalled, the whole pipe holds.
// Optional feature: with BARRET_RANGE_CHECK_EN defined, io.dout_err flags an
// operand >= Q seen at acceptance. The flag follows its item to the output.
module barret_modmul_pipe
  import barret_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  barret_modmul_pipe_if.slave  io
);

  if (MU != mu_of(Q, K) || (64'(Q - 1) * 64'(Q - 1)) >= (64'd1 << PW)
      || MU >= (1 << MUW)) begin : g_param_check
    $error("barret_pkg: MU, Q, K or PW are inconsistent");
  end

  logic          advance;
  logic          out_valid_w;
  logic          v1_q, v1_d;
  logic [PW-1:0] x1_q, x1_d;

  assign advance     = !out_valid_w || io.out_ready;
  assign io.in_ready = advance;
  assign io.out_valid = out_valid_w;

  always_comb begin
    v1_d = v1_q;
    x1_d = x1_q;
    if (advance) begin
      v1_d = io.in_valid;
      x1_d = PW'(io.din_a) * PW'(io.din_b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      x1_q <= '0;
    end else begin
      v1_q <= v1_d;
      x1_q <= x1_d;
    end
  end

  barret_reduce_pipe u_reduce (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .x_valid (v1_q),
    .x       (x1_q),
    .r_valid (out_valid_w),
    .r       (io.dout_r)
  );

`ifdef BARRET_RANGE_CHECK_EN
  // err_q[i] travels alongside stage i+1, so err_q[3] lines up with out_valid.
  logic [3:0] err_q, err_d;
  logic       range_bad;

  assign range_bad = (io.din_a >= QW'(Q)) || (io.din_b >= QW'(Q));

  always_comb begin
    err_d = err_q;
    if (advance) begin
      err_d = {err_q[2:0], range_bad};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign io.dout_err = err_q[3];
`endif

endmodule
